writeback_regfile: RTL
======================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL have parameter data_bits, default 32, datapath width in bits.
REQ-002 SHALL have parameter reg_count, default 32, number of architectural registers, with x0 included.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port wb_valid, input, 1 bit: MEM/WB stage holds a real instruction, not a bubble.
REQ-006 SHALL have port reg_write, input, 1 bit: instruction writes rd.
REQ-007 SHALL have port mem_to_reg, input, 1 bit: 1 selects data_memory_out, 0 selects alu_result.
REQ-008 SHALL have port alu_result, input, data_bits wide: MEM/WB ALU result.
REQ-009 SHALL have port data_memory_out, input, data_bits wide: MEM/WB load data.
REQ-010 SHALL have port rd, input, 5 bits: destination register, instruction bits 11:7.
REQ-011 SHALL have ports rs1_addr and rs2_addr, input, 5 bits each: ID-stage read addresses.
REQ-012 SHALL have ports rs1_data and rs2_data, output, data_bits wide each: ID-stage read data.
REQ-013 SHALL have port wb_data, output, data_bits wide: selected write-back value, for the forwarding unit.
REQ-014 SHALL have port wb_we, output, 1 bit: qualified write enable, equal to wb_valid and reg_write and rd not equal to 0.
REQ-015 SHALL have port instret, output, 64 bits: count of retired instructions.

Function
REQ-016 wb_data SHALL equal data_memory_out when mem_to_reg is 1, and alu_result otherwise; it is combinational.
REQ-017 On each rising clk edge with wb_we at 1, register[rd] SHALL be loaded with wb_data.
REQ-018 Register x0 SHALL always read 0; writes to rd=0 SHALL be discarded.
REQ-019 Reads SHALL be combinational: rsN_data equals register[rsN_addr].
REQ-020 Read-during-write bypass: when wb_we=1 and rsN_addr=rd, rsN_data SHALL equal wb_data in the same cycle, giving zero-cycle write-to-read latency.
REQ-021 Both read ports SHALL bypass independently; rs1_addr=rs2_addr=rd SHALL return wb_data on both ports.
REQ-022 The bypass SHALL never apply when rsN_addr=0; in that case rsN_data SHALL be 0.
REQ-023 instret SHALL increment by 1 on each rising clk edge with wb_valid=1, regardless of reg_write.
REQ-024 instret SHALL wrap from 2^64-1 to 0 with no flag.
REQ-025 wb_valid=0 SHALL suppress both the register write and the instret increment, even if reg_write=1.
REQ-026 Addresses of reg_count or greater, when reg_count is less than 32, SHALL read 0 and SHALL ignore writes.

Reset
REQ-027 Asserting rst_n=0 SHALL asynchronously clear all registers and instret to 0, independent of clk.
REQ-028 While rst_n=0, writes SHALL be blocked and rsN_data SHALL read 0; wb_data and wb_we remain combinational functions of their inputs.
REQ-029 After rst_n deassertion, the first write SHALL take effect on the first rising clk edge at which rst_n=1.
REQ-030 A reset asserted mid-operation SHALL discard any write coinciding with that edge.

Structure
REQ-031 Constants SHALL be placed in the shared core package: register-address width (5), x0 index, and instret width (64).
REQ-032 The block SHALL have one natural sub-module, regfile_core: the storage array, with async clear, one write port and two raw read ports.
REQ-033 The write-data mux, bypass logic and instret counter SHALL live in writeback_regfile.

Verification
REQ-034 Reset then read all registers -> every rsN_data equals 0 and instret equals 0.
REQ-035 Write 0xDEADBEEF to x5 (mem_to_reg=0), then read rs1=5 next cycle -> 0xDEADBEEF; with rd=0 -> x0 still reads 0 and wb_we=0.
REQ-036 Bypass: wb_we=1, rd=7, data_memory_out=0x12345678, mem_to_reg=1, rs1=rs2=7 in the same cycle -> both read 0x12345678 before the edge.
REQ-037 Bubble: wb_valid=0, reg_write=1, rd=3, value 0xFFFF -> x3 unchanged and instret unchanged; 10 valid instructions with reg_write=0 -> instret=10.
REQ-038 Preload instret near wrap: 2^64-1 followed by one valid instruction -> instret=0.
REQ-039 Assert rst_n mid-cycle between edges after writing x9=0xA5A5A5A5 -> x9 reads 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/writeback_regfile_pkg.sv
// Shared constants and helpers for the write-back stage and its register file.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package writeback_regfile_pkg;

  // Architectural register address width (instruction rd/rs fields are 5 bits)
  localparam int REG_ADDR_BITS = 5;

  // Hard-wired zero register index
  localparam logic [REG_ADDR_BITS-1:0] X0_IDX = '0;

  // Retired-instruction counter width
  localparam int INSTRET_BITS = 64;

  // True when an address maps onto an implemented register (covers reg_count < 32)
  function automatic logic addr_in_range(input logic [REG_ADDR_BITS-1:0] addr,
                                         input int                       count);
    return (int'(addr) < count);
  endfunction

endpackage

// File: rtl/writeback_regfile_regfile_core.sv
// Register storage: async-cleared array, one write port, two raw combinational read ports.
// Latency: writes land on the rising edge; reads are combinational (no bypass here).
// Backpressure: none; a write is accepted every cycle i_we is high.
module regfile_core
  import writeback_regfile_pkg::*;
#(
  parameter int data_bits = 32,
  parameter int reg_count = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [REG_ADDR_BITS-1:0] i_waddr,
  input  logic [data_bits-1:0]     i_wdata,
  input  logic [REG_ADDR_BITS-1:0] i_raddr1,
  input  logic [REG_ADDR_BITS-1:0] i_raddr2,
  output logic [data_bits-1:0]     o_rdata1,
  output logic [data_bits-1:0]     o_rdata2
);

  // x0 has no storage; entries start at index 1 so x0 and out-of-range
  // addresses never match a row and fall through to the zero default.
  logic [data_bits-1:0] r_regs [1:reg_count-1];

  // Storage update: async clear on reset, otherwise write the addressed row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < reg_count; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      for (int i = 1; i < reg_count; i++) begin
        if (i_waddr == REG_ADDR_BITS'(i)) begin
          r_regs[i] <= i_wdata;
        end
      end
    end
  end

  // Raw read muxes: unmatched addresses (x0, beyond reg_count) read zero
  always_comb begin
    o_rdata1 = '0;
    o_rdata2 = '0;
    for (int i = 1; i < reg_count; i++) begin
      if (i_raddr1 == REG_ADDR_BITS'(i)) begin
        o_rdata1 = r_regs[i];
      end
      if (i_raddr2 == REG_ADDR_BITS'(i)) begin
        o_rdata2 = r_regs[i];
      end
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage: result mux, qualified register write, read bypass and instret counter.
// Latency: wb_data/wb_we/rsN_data combinational (zero-cycle write-to-read); state updates on the edge.
// Backpressure: none; one instruction retires per cycle whenever wb_valid is high.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int data_bits = 32,
  parameter int reg_count = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_valid,
  input  logic                     reg_write,
  input  logic                     mem_to_reg,
  input  logic [data_bits-1:0]     alu_result,
  input  logic [data_bits-1:0]     data_memory_out,
  input  logic [REG_ADDR_BITS-1:0] rd,
  input  logic [REG_ADDR_BITS-1:0] rs1_addr,
  input  logic [REG_ADDR_BITS-1:0] rs2_addr,
  output logic [data_bits-1:0]     rs1_data,
  output logic [data_bits-1:0]     rs2_data,
  output logic [data_bits-1:0]     wb_data,
  output logic                     wb_we,
  output logic [INSTRET_BITS-1:0]  instret
);

  logic [data_bits-1:0]    w_wb_data;
  logic                    w_wb_we;
  logic [data_bits-1:0]    w_raw1;
  logic [data_bits-1:0]    w_raw2;
  logic                    w_byp1;
  logic                    w_byp2;
  logic [INSTRET_BITS-1:0] r_instret;

  // Result select and write qualification; bubbles and x0 never write
  always_comb begin
    w_wb_data = mem_to_reg ? data_memory_out : alu_result;
    w_wb_we   = wb_valid & reg_write & (rd != X0_IDX);
  end

  assign wb_data = w_wb_data;
  assign wb_we   = w_wb_we;

  regfile_core #(
    .data_bits (data_bits),
    .reg_count (reg_count)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_wb_we),
    .i_waddr  (rd),
    .i_wdata  (w_wb_data),
    .i_raddr1 (rs1_addr),
    .i_raddr2 (rs2_addr),
    .o_rdata1 (w_raw1),
    .o_rdata2 (w_raw2)
  );

  // Bypass hit per port: w_wb_we already excludes rd=0, so x0 can never bypass
  always_comb begin
    w_byp1 = w_wb_we && (rs1_addr == rd) && addr_in_range(rs1_addr, reg_count);
    w_byp2 = w_wb_we && (rs2_addr == rd) && addr_in_range(rs2_addr, reg_count);
  end

  // Read ports: forced to zero in reset, else pending write-back wins over storage
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rst_n) begin
      rs1_data = w_byp1 ? w_wb_data : w_raw1;
      rs2_data = w_byp2 ? w_wb_data : w_raw2;
    end
  end

  // Retired-instruction count: every valid instruction, wraps silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (wb_valid) begin
      r_instret <= r_instret + 1'b1;
    end
  end

  assign instret = r_instret;

endmodule
